// File: rtl/qru32.sv
// qru32: iterative restoring radix-2 divider for RV32M div/divu/rem/remu.
// Optional macro QRU_FASTPATH_EN: divide-by-zero and signed overflow finish in one cycle.
`default_nettype none

module qru32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      divctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CALC  = 2'd2,
    FIX   = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [XLEN-1:0] a_q, b_q;
  logic [1:0]      op;
  logic [XLEN-1:0] dvd, dvs;
  logic [XLEN:0]   rem;
  logic [4:0]      cnt;
  logic            q_neg, r_neg;

  logic [XLEN+1:0] sh, diff;
  logic [XLEN-1:0] quot, remv, fix_res;
  logic            fix_bz, fix_ovf;

`ifdef QRU_FASTPATH_EN
  logic in_special;
  assign in_special = (b == '0) || (!divctl[0] && (a == MIN_NEG) && (b == '1));
`endif

  // One extra guard bit so a negative trial difference shows up in the MSB.
  assign sh   = {rem, dvd[XLEN-1]};
  assign diff = sh - {2'b00, dvs};

  assign quot    = q_neg ? -dvd : dvd;
  assign remv    = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign fix_bz  = (b_q == '0);
  assign fix_ovf = !op[0] && (a_q == MIN_NEG) && (b_q == '1);

  always_comb begin
    fix_res = op[1] ? remv : quot;
    if (fix_bz) begin
      fix_res = op[1] ? a_q : '1;
    end else if (fix_ovf) begin
      fix_res = op[1] ? '0 : MIN_NEG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
`ifdef QRU_FASTPATH_EN
          state_nxt = in_special ? FIX : SETUP;
`else
          state_nxt = SETUP;
`endif
        end
      end
      SETUP:   state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op     <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            op  <= divctl;
          end
        end
        SETUP: begin
          if (!op[0]) begin
            dvd   <= a_q[XLEN-1] ? -a_q : a_q;
            dvs   <= b_q[XLEN-1] ? -b_q : b_q;
            q_neg <= a_q[XLEN-1] ^ b_q[XLEN-1];
            r_neg <= a_q[XLEN-1];
          end else begin
            dvd   <= a_q;
            dvs   <= b_q;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
          end
          rem <= '0;
          cnt <= '0;
        end
        CALC: begin
          // Quotient bits shift into dvd as dividend bits shift out.
          dvd <= {dvd[XLEN-2:0], ~diff[XLEN+1]};
          rem <= diff[XLEN+1] ? sh[XLEN:0] : diff[XLEN:0];
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/qru32.md
# qru32

Iterative quotient/remainder unit (QRU) implementing RV32M `div`, `divu`, `rem` and `remu`. It sits beside the ALU and multiplier in the execute stage. It consumes the register-file read operands (rs1, rs2) and `func3[1:0]`, and returns a 32-bit result on the register write-back path. It is multi-cycle: control stalls PC update and `regwe` while `busy` is high, and writes back on `done`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `divctl`  input  2  `func3[1:0]`: 00 div, 01 divu, 10 rem, 11 remu.
- `a`  input  32  dividend (rs1); captured on accepted `start`.
- `b`  input  32  divisor (rs2); captured on accepted `start`.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; `result` is valid.
- `result`  output  32  quotient or remainder; held until the next accepted `start`.

## Operation
- State machine: IDLE, SETUP, CALC, FIX.
- IDLE:
  - `start`=1 latches `a`, `b` and `divctl`; next state is SETUP.
  - `start`=0 stays in IDLE.
- SETUP:
  - Signed ops (div/rem): latch |a|, |b|; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Unsigned ops: operands pass through, signs = 0.
  - Clear the 33-bit partial remainder and the iteration counter; next state is CALC.
- CALC: restoring radix-2, one quotient bit per cycle, MSB first.
  - Shift {rem, dvd} left by 1.
  - Trial-subtract |b| using 33-bit arithmetic.
  - Keep the difference and set the quotient bit if the difference is non-negative.
  - The 5-bit counter runs 0..31; at 31 the next state is FIX.
- FIX: apply sign correction by two's-complement negation, then select the quotient (div/divu) or remainder (rem/remu).
  - Special-case override, taking priority:
    - b==0: quotient = 0xFFFFFFFF; remainder = original `a`.
    - Signed overflow (a==0x80000000, b==0xFFFFFFFF): quotient = 0x80000000, remainder = 0. The iteration yields this naturally; the override makes it explicit.
  - Next state is IDLE; register `result` and pulse `done`.
- `start` while `busy`=1 is ignored and does not disturb the captured operands.
- `busy` is 0 in the cycle `done`=1, so `start` in that cycle is accepted (back-to-back operation).

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, internal registers 0.
- `rst` asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - The in-flight operation is discarded.
  - No `done` is produced after release.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 from after E0 until after E34: 1 SETUP + 32 CALC + 1 FIX.
  - `done`=1 and `result` valid between E34 and E35.
  - Latency is 34 cycles and data-independent, unless `QRU_FASTPATH_EN` is defined.
- `result` updates only at the edge that raises `done`.

## Configuration
- Macro: `QRU_FASTPATH_EN`.
- Defined: an accepted `start` with b==0 or signed overflow skips SETUP and CALC.
  - State goes IDLE → FIX after E0.
  - `busy`=1 for one cycle; `done` and `result` appear after E1 (latency 1).
  - All other operands keep 34-cycle latency.
- Undefined: all operations take 34 cycles; special cases are resolved in FIX.
- Results are identical in both builds; only latency differs.

## Test plan
- **Unsigned divide:** divu a=100, b=7 → `result`=14, `done` exactly 34 cycles after `start`; remu same operands → 2.
- **Signed divide:** div a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3); rem → 0xFFFFFFFF (−1); rem a=7, b=0xFFFFFFFE → 1.
- **Divide by zero:** div a=5, b=0 → 0xFFFFFFFF; divu → 0xFFFFFFFF; rem → 5; remu a=0x80000000, b=0 → 0x80000000. Latency is 1 with `QRU_FASTPATH_EN`, 34 without.
- **Signed overflow:** div a=0x80000000, b=0xFFFFFFFF → 0x80000000; rem → 0.
- **Start while busy:** pulse `start` with new operands at cycle 10 of an operation → ignored; the original result is returned at the original time.
- **Reset and back-to-back:**
  - Assert `rst` during CALC → `busy`=0, `done`=0, `result`=0 at once; no stray `done` after release.
  - `start` in the `done` cycle → second operation accepted and completes 34 cycles later.
